// File: rtl/ifconv_wb_buf.sv
// ifconv_wb_buf
//   Small writeback FIFO sitting after the integer-to-float converter. The
//   destination tag runs down a two-stage pipeline that follows the
//   converter's clkEn, so it lines up with cnv_res/cnv_alt. Completed results
//   are queued until the FP writeback port grants them.
//
//   Optional feature: define IFCONV_WB_BYPASS_EN to compile in an empty-FIFO
//   bypass (result presented on wb_* in the push cycle; not stored if granted).
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active low
//   clkEn     in   converter pipeline advance enable
//   en        in   conversion issue strobe (qualifies reg_tag)
//   reg_tag   in   destination tag [TAGW]
//   cnv_alt   in   converter result valid
//   cnv_res   in   converter result [82]
//   cnv_rtyp  in   converter result type [2]
//   wb_grant  in   writeback port granted this cycle
//   wb_req    out  head entry valid
//   wb_res    out  head result [82]   (zero when empty)
//   wb_rtyp   out  head type [2]      (zero when empty)
//   wb_tag    out  head tag [TAGW]    (zero when empty)
//   stall     out  upstream must not issue
//   ovf       out  sticky overflow flag, cleared by reset only
module ifconv_wb_buf #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clkEn,
  input  logic            en,
  input  logic [TAGW-1:0] reg_tag,
  input  logic            cnv_alt,
  input  logic [81:0]     cnv_res,
  input  logic [1:0]      cnv_rtyp,
  input  logic            wb_grant,
  output logic            wb_req,
  output logic [81:0]     wb_res,
  output logic [1:0]      wb_rtyp,
  output logic [TAGW-1:0] wb_tag,
  output logic            stall,
  output logic            ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 82 + 2 + TAGW;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 2);

  logic [TAGW-1:0] tag_r1, tag_r2;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [EW-1:0]   mem [DEPTH];

  logic push, empty, full, store, fifo_pop, do_write;
  logic [EW-1:0] head;

  assign push     = cnv_alt & clkEn;
  assign empty    = (count == '0);
  assign full     = (count == FULL_LVL);
  // wb_req is never set by the FIFO while empty, so a grant there is ignored.
  assign fifo_pop = wb_grant & ~empty;

`ifdef IFCONV_WB_BYPASS_EN
  logic bypass;
  assign bypass = empty & push;
  // A bypassed result that is granted leaves straight away and is never queued.
  assign store  = push & ~(bypass & wb_grant);
`else
  assign store  = push;
`endif

  // At full, a push only lands if a pop frees the slot in the same edge.
  assign do_write = store & (~full | fifo_pop);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_r1 <= '0;
      tag_r2 <= '0;
    end else if (clkEn) begin
      // A slot without an issue carries a zero tag rather than stale bus data.
      tag_r1 <= en ? reg_tag : '0;
      tag_r2 <= tag_r1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (store & full & ~fifo_pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= {cnv_res, cnv_rtyp, tag_r2};
  end

  always_comb begin
    wb_req = ~empty;
    {wb_res, wb_rtyp, wb_tag} = empty ? '0 : head;
`ifdef IFCONV_WB_BYPASS_EN
    if (bypass) begin
      wb_req = 1'b1;
      {wb_res, wb_rtyp, wb_tag} = {cnv_res, cnv_rtyp, tag_r2};
    end
`endif
  end

  assign stall = (count >= STALL_LVL);

endmodule
